// File: rtl/alu_div_sequencer_if.sv
// Issue/writeback bundle for alu_div_sequencer.
// master: decode/issue + writeback side. slave: the divide sequencer.
// Handshake: a result transfers on a rising edge where outValid & outReady.
// outValid, quotient, remainder and divByZero stay stable until that edge.
// start is a single-cycle request and is only looked at while busy is low.
interface alu_div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             isSigned;
  logic             busy;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             divByZero;

  modport master (
    output start, dividend, divisor, isSigned, outReady,
    input  busy, outValid, quotient, remainder, divByZero
  );

  modport slave (
    input  start, dividend, divisor, isSigned, outReady,
    output busy, outValid, quotient, remainder, divByZero
  );
endinterface

// File: rtl/alu_div_sequencer.sv
// alu_div_sequencer: multi-cycle restoring divider that borrows the ALU SUB
// datapath. While busy it drives the ALU inputs and uses the ALU borrow
// (carry) to decide each quotient bit; one bit per cycle, MSB first.
// Optional feature macro: SIGNED_DIV_EN adds two's-complement division with a
// one-cycle FIXUP state that applies the result signs.
// dbg_state exposes the FSM state (0 IDLE, 1 DIVIDE, 2 FIXUP, 3 DONE).
module alu_div_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] OP_SUB  = 4'd10,
  parameter logic [3:0] OP_PASS = 4'd13
) (
  input  logic                clk,
  input  logic                rst,
  alu_div_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]    aluA,
  output logic [WIDTH-1:0]    aluB,
  output logic [3:0]          aluOpSel,
  input  logic [WIDTH-1:0]    aluResult,
  input  logic                aluCarry,
  output logic [1:0]          dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem_acc;   // partial remainder R
  logic [WIDTH-1:0] quo_acc;   // dividend shifting out / quotient shifting in (Q)
  logic [WIDTH-1:0] div_reg;   // divisor magnitude D
  logic [CW-1:0]    count;

  logic             qbit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

`ifdef SIGNED_DIV_EN
  logic neg_quo;
  logic neg_rem;
`else
  logic unused_is_signed;
  assign unused_is_signed = bus.isSigned;
`endif

  assign dbg_state = state;

  // One restoring step. aluA already holds {R[W-2:0], Q[W-1]} and aluB holds D.
  // If R's MSB is set the shifted value exceeds any divisor, so subtract
  // regardless of borrow; the modulo-2^W ALU difference is exact then.
  always_comb begin
    qbit     = rem_acc[WIDTH-1] | ~aluCarry;
    rem_next = qbit ? aluResult : aluA;
    quo_next = {quo_acc[WIDTH-2:0], qbit};
  end

  // Operands as seen by the unsigned core: magnitudes for signed requests.
  always_comb begin
    op_a = bus.dividend;
    op_b = bus.divisor;
`ifdef SIGNED_DIV_EN
    if (bus.isSigned && bus.dividend[WIDTH-1]) op_a = -bus.dividend;
    if (bus.isSigned && bus.divisor[WIDTH-1])  op_b = -bus.divisor;
`endif
  end

  // Control FSM with registered outputs and iteration datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rem_acc       <= '0;
      quo_acc       <= '0;
      div_reg       <= '0;
      count         <= '0;
      bus.busy      <= 1'b0;
      bus.outValid  <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.divByZero <= 1'b0;
      aluA          <= '0;
      aluB          <= '0;
      aluOpSel      <= OP_PASS;
`ifdef SIGNED_DIV_EN
      neg_quo       <= 1'b0;
      neg_rem       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.busy     <= 1'b0;
          bus.outValid <= 1'b0;
          aluOpSel     <= OP_PASS;
          aluA         <= '0;
          aluB         <= '0;
          if (bus.start) begin
            quo_acc  <= op_a;
            div_reg  <= op_b;
            rem_acc  <= '0;
            count    <= '0;
            bus.busy <= 1'b1;
`ifdef SIGNED_DIV_EN
            neg_quo  <= bus.isSigned & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_rem  <= bus.isSigned & bus.dividend[WIDTH-1];
`endif
            if (bus.divisor == '0) begin
              // Divide by zero skips the iterations; the result is fixed.
              state         <= DONE;
              bus.outValid  <= 1'b1;
              bus.quotient  <= '1;
              bus.remainder <= bus.dividend;
              bus.divByZero <= 1'b1;
            end else begin
              state         <= DIVIDE;
              bus.divByZero <= 1'b0;
              aluOpSel      <= OP_SUB;
              aluA          <= {{(WIDTH-1){1'b0}}, op_a[WIDTH-1]};
              aluB          <= op_b;
            end
          end
        end

        DIVIDE: begin
          rem_acc <= rem_next;
          quo_acc <= quo_next;
          count   <= count + 1'b1;
          if (count == LAST_ITER) begin
            // Hand the ALU back as soon as the last bit is decided.
            aluOpSel <= OP_PASS;
            aluA     <= '0;
            aluB     <= '0;
`ifdef SIGNED_DIV_EN
            state    <= FIXUP;
`else
            state         <= DONE;
            bus.outValid  <= 1'b1;
            bus.quotient  <= quo_next;
            bus.remainder <= rem_next;
`endif
          end else begin
            // Next step's shifted remainder; quo_next's MSB is quo_acc[W-2].
            aluA <= {rem_next[WIDTH-2:0], quo_acc[WIDTH-2]};
            aluB <= div_reg;
          end
        end

`ifdef SIGNED_DIV_EN
        FIXUP: begin
          // Quotient negative when signs differ; remainder follows dividend.
          state         <= DONE;
          bus.outValid  <= 1'b1;
          bus.quotient  <= neg_quo ? -quo_acc : quo_acc;
          bus.remainder <= neg_rem ? -rem_acc : rem_acc;
        end
`endif

        DONE: begin
          if (bus.outReady) begin
            state        <= IDLE;
            bus.outValid <= 1'b0;
            bus.busy     <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          bus.busy     <= 1'b0;
          bus.outValid <= 1'b0;
          aluOpSel     <= OP_PASS;
          aluA         <= '0;
          aluB         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Testbench for alu_div_sequencer: directed divide vectors against a plain
// arithmetic model, with a bench-side ALU providing SUB/PASS behaviour.
module tb_alu_div_sequencer;
  localparam int W = 32;
`ifdef SIGNED_DIV_EN
  localparam int  DIV_LAT   = 34;
  localparam bit  SIGNED_EN = 1'b1;
`else
  localparam int  DIV_LAT   = 33;
  localparam bit  SIGNED_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] aluA, aluB, aluResult;
  logic [3:0]   aluOpSel;
  logic         aluCarry;
  logic [1:0]   dbg_state;
  bit           mon_en = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rem_q[$];
  logic         exp_dbz_q[$];

  alu_div_sequencer_if #(.WIDTH(W)) bus ();

  alu_div_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .aluA      (aluA),
    .aluB      (aluB),
    .aluOpSel  (aluOpSel),
    .aluResult (aluResult),
    .aluCarry  (aluCarry),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Bench ALU: SUB reports borrow in carry, everything else passes a through
  always_comb begin
    aluResult = aluA;
    aluCarry  = 1'b0;
    if (aluOpSel == 4'd10) begin
      aluResult = aluA - aluB;
      aluCarry  = (aluA < aluB);
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model from plain arithmetic
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
    longint sa, sb;
    dbz = (b == '0);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (SIGNED_EN && sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Scoreboard compare: every cycle after reset
  always @(negedge clk) begin
    if (rst && mon_en) begin
      if (bus.outValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: actual=1 expected=0");
        end else begin
          check("quotient", bus.quotient, exp_q[0]);
          check("remainder", bus.remainder, exp_rem_q[0]);
          check("div_by_zero", W'(bus.divByZero), W'(exp_dbz_q[0]));
          check("busy_while_valid", W'(bus.busy), 1);
          if (bus.outReady) begin
            void'(exp_q.pop_front());
            void'(exp_rem_q.pop_front());
            void'(exp_dbz_q.pop_front());
          end
        end
      end
      if (!bus.busy) begin
        check("idle_opsel", W'(aluOpSel), 13);
        check("idle_alu_a", aluA, 0);
        check("idle_alu_b", aluB, 0);
      end
    end
  end

  // Issue one divide; hold keeps outReady low that many cycles while start is pulsed
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, input int hold);
    logic [W-1:0] q, r;
    logic         dbz;
    int           lat;
    model(a, b, sgn, q, r, dbz);
    exp_q.push_back(q);
    exp_rem_q.push_back(r);
    exp_dbz_q.push_back(dbz);
    bus.dividend = a;
    bus.divisor  = b;
    bus.isSigned = sgn;
    bus.outReady = (hold == 0);
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.outValid && lat < 100);
    check("latency", lat, (b == '0) ? 1 : DIV_LAT);
    if (!bus.outValid) begin
      exp_q.delete();
      exp_rem_q.delete();
      exp_dbz_q.delete();
      return;
    end
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = $urandom;
        bus.divisor  = $urandom_range(1, 100);
      end
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.outReady = 1'b1;
    end
    @(posedge clk);
    #1;
    check("post_handshake_busy", W'(bus.busy), 0);
    check("post_handshake_valid", W'(bus.outValid), 0);
    check("post_handshake_state", W'(dbg_state), 0);
  endtask

  // Abort a divide mid-iteration with asynchronous reset
  task automatic reset_mid_op();
    bus.dividend = 32'd1000000;
    bus.divisor  = 32'd3;
    bus.isSigned = 1'b0;
    bus.outReady = 1'b1;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", W'(bus.busy), 0);
    check("abort_valid", W'(bus.outValid), 0);
    check("abort_opsel", W'(aluOpSel), 13);
    check("abort_quotient", bus.quotient, 0);
    check("abort_alu_a", aluA, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Stimulus and final report
  initial begin
    logic [W-1:0] mq, mr;
    logic         mdbz;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.isSigned = 1'b0;
    bus.outReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", W'(bus.busy), 0);
    check("reset_valid", W'(bus.outValid), 0);
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
    check("reset_dbz", W'(bus.divByZero), 0);
    check("reset_opsel", W'(aluOpSel), 13);
    check("reset_alu_a", aluA, 0);
    check("reset_alu_b", aluB, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Pin the model to hand-computed values
    model(32'd100, 32'd7, 1'b0, mq, mr, mdbz);
    check("model_100_7_q", mq, 32'd14);
    check("model_100_7_r", mr, 32'd2);
    model(32'hFFFFFFFF, 32'h80000001, 1'b0, mq, mr, mdbz);
    check("model_big_q", mq, 32'd1);
    check("model_big_r", mr, 32'h7FFFFFFE);
    model(32'd5, 32'd0, 1'b0, mq, mr, mdbz);
    check("model_dz_q", mq, 32'hFFFFFFFF);
    check("model_dz_r", mr, 32'd5);
    check("model_dz_flag", W'(mdbz), 1);
`ifdef SIGNED_DIV_EN
    model(32'hFFFFFFF9, 32'd2, 1'b1, mq, mr, mdbz);
    check("model_neg7_2_q", mq, 32'hFFFFFFFD);
    check("model_neg7_2_r", mr, 32'hFFFFFFFF);
`endif

    run_div(32'd100, 32'd7, 1'b0, 0);
    run_div(32'hFFFFFFFF, 32'h80000001, 1'b0, 0);
    run_div(32'd5, 32'd0, 1'b0, 0);
    run_div(32'd3, 32'd10, 1'b0, 0);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, 0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
    run_div(32'h12345678, 32'h10, 1'b0, 10);
    run_div(32'd0, 32'd9, 1'b0, 0);
    reset_mid_op();
    run_div(32'd9, 32'd3, 1'b0, 0);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, 0);
    run_div(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 0);
    run_div(32'hFFFFFFF9, 32'd0, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      run_div($urandom, $urandom_range(1, 32'h0001FFFF), 1'b0, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
